hq_stream_scheduler: RTL and testbench
======================================

Name: hq_stream_scheduler

Overview:
- Sequencer in front of the H·S_q matrix multiplier (c_mac-based, 4x4 complex H times 4x2 S_q, 16 q indices).
- Accepts one 4x4 complex H matrix as a 16-beat row-major stream and stores it in an internal buffer.
- Replays H[i][k] in the (q, i, j, k) order the multiplier consumes: 16 q x 4 i x 2 j x 4 k = 512 beats.
- Counts the 128 returned results, reports the current q, and flags protocol errors.

Parameters:
- N, 16, width of each real/imag sample (signed, fixed point, passed through unchanged).
- NUM_Q, 16, number of S_q matrices to sequence (1..16).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a load+compute job; sampled only in IDLE
- h_in_valid  in  1  H input beat valid
- h_in_ready  out  1  scheduler accepts H beats (high only in LOAD)
- h_in_r  in  N  H real part, row-major order
- h_in_i  in  N  H imag part, row-major order
- mm_start  out  1  one-cycle pulse to multiplier at job begin
- mm_h_valid  out  1  H element presented to multiplier
- mm_h_ready  in  1  multiplier consumes element this cycle (its mac_en)
- mm_h_r  out  N  H[i][k] real
- mm_h_i  out  N  H[i][k] imag
- mm_res_valid  in  1  multiplier output element valid
- q_index  out  4  q of element currently being fed/awaited
- i_idx  out  2  current row i
- j_idx  out  1  current column j
- busy  out  1  high in LOAD, FEED, WAIT
- done  out  1  one-cycle pulse when all results for NUM_Q matrices are received
- err  out  1  sticky protocol error flag, cleared on start or rst

Behaviour:
- Reset values: state IDLE, all counters 0, all outputs 0. The H buffer is not cleared; its contents are don't-care.
- States are IDLE, LOAD, FEED, WAIT and DONE. All outputs are registered or decoded from registered state only, with no combinational input-to-output path.
- IDLE:
  - start=1 moves to LOAD and clears load_cnt, q, i, j, k and err.
  - start in any other state is ignored.
- LOAD:
  - h_in_ready=1.
  - Each cycle with h_in_valid=1, write buf[load_cnt] and increment load_cnt (0..15).
  - The beat with load_cnt=15 moves to FEED and sets mm_start=1 for the next cycle only.
  - h_in_valid outside LOAD is ignored.
- FEED:
  - mm_h_valid=1 and mm_h_r/i = buf[{i,k}], so the first element appears the cycle after the 16th load beat.
  - On mm_h_ready, k increments.
  - Acceptance at k=3 moves to WAIT with k wrapping to 0.
  - mm_h_ready=0 holds the element stable with no timeout.
  - mm_res_valid in FEED sets err and does not advance counters.
- WAIT:
  - mm_h_valid=0.
  - On mm_res_valid, advance j. On a j 1->0 wrap, advance i. On an i 3->0 wrap, advance q.
  - If q=NUM_Q-1, i=3 and j=1 at that result, go to DONE; otherwise go to FEED next cycle.
  - mm_h_ready in WAIT is ignored.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE.
- Counts per job: 16 load beats, NUM_Q*32 feed beats, NUM_Q*8 results. With NUM_Q=16 that is 512 feed beats and 128 results.
- Minimum job length, with ready always 1 and a 1-cycle result return, is 16 load + NUM_Q*8*(4 feed + 1 wait) + 1 done cycles.
- q_index, i_idx and j_idx reflect the element being fed or awaited and are stable through WAIT.
- rst asserted mid-job returns to IDLE on the next edge, with no done and outputs at reset values.
- rst and start together: rst wins.
- Width handling: data passes through bit-exact, with no scaling or saturation.

Test Plan:
- Load ramp with H[r][c] = (r*4+c, -(r*4+c)), mm_h_ready=1, result returned 1 cycle after each k=3 -> feed sequence per (q,i,j) is 4i..4i+3 with imag negated; 512 beats; done asserted exactly once after the 128th result; busy falls with done.
- Backpressure: mm_h_ready toggled 1,0,0,1 during FEED -> mm_h_r/i held stable while ready=0; no beat skipped or duplicated; k sequence 0,1,2,3 preserved.
- Indices: capture q_index/i_idx/j_idx at each mm_res_valid -> sequence (0,0,0),(0,0,1),(0,1,0)...(15,3,1); no q above 15.
- Protocol error: pulse mm_res_valid during FEED at q=2 -> err=1 and stays 1; counters unchanged; next start clears err.
- Load gaps plus NUM_Q=2: h_in_valid pattern 1,0,1,... over 16 beats -> only valid beats stored; FEED starts the cycle after the 16th beat with mm_start pulse; done after 16 results.
- Reset mid-job: rst at q=5 in FEED -> next cycle in IDLE with mm_h_valid=0, busy=0, done=0; a new start re-runs from q=0.

Source files
------------

// File: rtl/hq_stream_scheduler.sv
// ---------------------------------------------------------------------------
// hq_stream_scheduler
//
// Sequencer in front of the H*S_q complex matrix multiplier. It takes one
// 4x4 complex H matrix as a 16-beat row-major stream, holds it in a local
// buffer, and replays H[i][k] in the (q, i, j, k) order the multiplier
// consumes: NUM_Q x 4 rows x 2 columns x 4 products. Each group of four
// products yields one result from the multiplier; the scheduler counts
// those results, reports which (q, i, j) is being fed or awaited, and
// flags a result that arrives while a group is still being fed.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start                begin a load+compute job (honoured only in IDLE)
//   h_in_valid/_ready    H input handshake (ready only while loading)
//   h_in_r, h_in_i       H sample, row-major, signed N-bit real/imag
//   mm_start             one-cycle pulse as the first element is presented
//   mm_h_valid/_ready    element handshake towards the multiplier
//   mm_h_r, mm_h_i       H[i][k] presented to the multiplier
//   mm_res_valid         multiplier produced one output element
//   q_index, i_idx, j_idx  indices of the element being fed or awaited
//   busy                 high while loading, feeding or waiting
//   done                 one-cycle pulse after the last result of the job
//   err                  sticky protocol error, cleared by start or rst
// ---------------------------------------------------------------------------
module hq_stream_scheduler #(
  parameter int N     = 16,
  parameter int NUM_Q = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         h_in_valid,
  output logic         h_in_ready,
  input  logic [N-1:0] h_in_r,
  input  logic [N-1:0] h_in_i,
  output logic         mm_start,
  output logic         mm_h_valid,
  input  logic         mm_h_ready,
  output logic [N-1:0] mm_h_r,
  output logic [N-1:0] mm_h_i,
  input  logic         mm_res_valid,
  output logic [3:0]   q_index,
  output logic [1:0]   i_idx,
  output logic         j_idx,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_Q = 4'(NUM_Q - 1);

  state_t       state_q;
  logic [3:0]   load_cnt_q;
  logic [3:0]   q_q;
  logic [1:0]   i_q;
  logic         j_q;
  logic [1:0]   k_q;
  logic         mm_start_q;
  logic         err_q;

  logic [N-1:0] hbuf_r_q [16];
  logic [N-1:0] hbuf_i_q [16];

  // NOTE: the H buffer is plain storage with no reset; every job overwrites
  // all 16 entries before any of them is read, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_LOAD && h_in_valid) begin
      hbuf_r_q[load_cnt_q] <= h_in_r;
      hbuf_i_q[load_cnt_q] <= h_in_i;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // comparison below sees the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      q_q        <= '0;
      i_q        <= '0;
      j_q        <= 1'b0;
      k_q        <= '0;
      mm_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mm_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LOAD;
            load_cnt_q <= '0;
            q_q        <= '0;
            i_q        <= '0;
            j_q        <= 1'b0;
            k_q        <= '0;
            err_q      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (h_in_valid) begin
            load_cnt_q <= load_cnt_q + 4'd1;
            if (load_cnt_q == 4'd15) begin
              state_q    <= S_FEED;
              mm_start_q <= 1'b1;
            end
          end
        end
        S_FEED: begin
          // A result while the group is still being fed is a protocol
          // violation; the element on offer is held rather than consumed.
          if (mm_res_valid) begin
            err_q <= 1'b1;
          end else if (mm_h_ready) begin
            k_q <= k_q + 2'd1;
            if (k_q == 2'd3) state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mm_res_valid) begin
            j_q <= ~j_q;
            if (j_q) begin
              i_q <= i_q + 2'd1;
              if (i_q == 2'd3) q_q <= q_q + 4'd1;
            end
            if (q_q == LAST_Q && i_q == 2'd3 && j_q) state_q <= S_DONE;
            else                                     state_q <= S_FEED;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; data is forced to zero outside
  // FEED so an idle scheduler drives no stale buffer contents.
  assign h_in_ready = (state_q == S_LOAD);
  assign mm_h_valid = (state_q == S_FEED);
  assign mm_h_r     = (state_q == S_FEED) ? hbuf_r_q[{i_q, k_q}] : '0;
  assign mm_h_i     = (state_q == S_FEED) ? hbuf_i_q[{i_q, k_q}] : '0;
  assign mm_start   = mm_start_q;
  assign q_index    = q_q;
  assign i_idx      = i_q;
  assign j_idx      = j_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_FEED) || (state_q == S_WAIT);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_hq_stream_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for hq_stream_scheduler. Two instances are built: one with
// NUM_Q=16 and one with NUM_Q=2. They share the stimulus; the one not
// selected is held in reset and the selected one's outputs are observed.
// Expected feed data and result indices are queued as H is loaded and are
// popped as the scheduler presents elements and receives results.
// ---------------------------------------------------------------------------
module tb_hq_stream_scheduler;
  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst          = 1'b1;
  logic         sel          = 1'b0;
  logic         start        = 1'b0;
  logic         h_in_valid   = 1'b0;
  logic [N-1:0] h_in_r       = '0;
  logic [N-1:0] h_in_i       = '0;
  logic         mm_h_ready   = 1'b0;
  logic         mm_res_valid = 1'b0;

  wire rst_a = rst | sel;
  wire rst_b = rst | ~sel;

  logic         a_hready, a_start, a_valid, a_j, a_busy, a_done, a_err;
  logic [N-1:0] a_h_r, a_h_i;
  logic [3:0]   a_q;
  logic [1:0]   a_i;
  logic         b_hready, b_start, b_valid, b_j, b_busy, b_done, b_err;
  logic [N-1:0] b_h_r, b_h_i;
  logic [3:0]   b_q;
  logic [1:0]   b_i;

  hq_stream_scheduler #(.N(N), .NUM_Q(16)) dut16 (
    .clk(clk), .rst(rst_a), .start(start),
    .h_in_valid(h_in_valid), .h_in_ready(a_hready), .h_in_r(h_in_r), .h_in_i(h_in_i),
    .mm_start(a_start), .mm_h_valid(a_valid), .mm_h_ready(mm_h_ready),
    .mm_h_r(a_h_r), .mm_h_i(a_h_i), .mm_res_valid(mm_res_valid),
    .q_index(a_q), .i_idx(a_i), .j_idx(a_j),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  hq_stream_scheduler #(.N(N), .NUM_Q(2)) dut2 (
    .clk(clk), .rst(rst_b), .start(start),
    .h_in_valid(h_in_valid), .h_in_ready(b_hready), .h_in_r(h_in_r), .h_in_i(h_in_i),
    .mm_start(b_start), .mm_h_valid(b_valid), .mm_h_ready(mm_h_ready),
    .mm_h_r(b_h_r), .mm_h_i(b_h_i), .mm_res_valid(mm_res_valid),
    .q_index(b_q), .i_idx(b_i), .j_idx(b_j),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  wire         o_hready = sel ? b_hready : a_hready;
  wire         o_start  = sel ? b_start  : a_start;
  wire         o_valid  = sel ? b_valid  : a_valid;
  wire [N-1:0] o_h_r    = sel ? b_h_r    : a_h_r;
  wire [N-1:0] o_h_i    = sel ? b_h_i    : a_h_i;
  wire [3:0]   o_q      = sel ? b_q      : a_q;
  wire [1:0]   o_i      = sel ? b_i      : a_i;
  wire         o_j      = sel ? b_j      : a_j;
  wire         o_busy   = sel ? b_busy   : a_busy;
  wire         o_done   = sel ? b_done   : a_done;
  wire         o_err    = sel ? b_err    : a_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0] hm_r [16];
  logic [N-1:0] hm_i [16];
  logic [31:0]  fq [$];
  logic [6:0]   iq [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a job, stream in H (optionally with idle gaps between beats) and
  // queue the expected feed sequence and result indices for nq matrices.
  task automatic load_h(input int nq, input bit gaps, input bit rnd);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_ready", o_hready, 1);
    check("load_busy", o_busy, 1);
    check("err_cleared_by_start", o_err, 0);
    for (int b = 0; b < 16; b++) begin
      if (gaps && b > 0) begin
        h_in_valid = 1'b0;
        h_in_r     = 16'hdead;
        h_in_i     = 16'hbeef;
        @(negedge clk);
      end
      if (rnd) begin
        hm_r[b] = N'($urandom);
        hm_i[b] = N'($urandom);
      end else begin
        hm_r[b] = N'(b);
        hm_i[b] = N'(-b);
      end
      h_in_valid = 1'b1;
      h_in_r     = hm_r[b];
      h_in_i     = hm_i[b];
      @(negedge clk);
    end
    h_in_valid = 1'b0;
    check("mm_start_after_16th_beat", o_start, 1);
    check("feed_after_16th_beat", o_valid, 1);
    check("ready_low_after_load", o_hready, 0);
    for (int q = 0; q < nq; q++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 2; j++) begin
          for (int k = 0; k < 4; k++) fq.push_back({hm_r[i*4+k], hm_i[i*4+k]});
          iq.push_back({4'(q), 2'(i), 1'(j)});
        end
  endtask

  // mode 0: ready always high; 1: ready 1,0,0,1 with start/h_in noise;
  // 2: inject a result during FEED at q=2; 3: reset during FEED at q=5.
  task automatic run_job(input int nq, input int mode);
    int          cyc;
    int          res_cnt;
    bit          seen_done;
    bit          aborted;
    bit          injected;
    bit          chk_err;
    bit          held_pending;
    bit          rdy;
    logic [31:0] held;
    logic [31:0] obs;
    logic [31:0] exp_d;
    logic [6:0]  exp_i;
    logic [3:0]  pat;
    res_cnt = 0; seen_done = 0; aborted = 0; injected = 0; chk_err = 0;
    held_pending = 0; held = '0; pat = 4'b1001;
    for (cyc = 0; cyc < 6000; cyc++) begin
      obs = {o_h_r, o_h_i};
      mm_res_valid = 1'b0;
      mm_h_ready   = 1'b0;
      if (chk_err) begin
        check("err_set_by_early_result", o_err, 1);
        chk_err = 0;
      end
      if (cyc == 1) check("mm_start_single_pulse", o_start, 0);
      if (o_done) begin
        seen_done = 1;
        break;
      end
      if (mode == 3 && o_valid && o_q == 4'd5) begin
        aborted = 1;
        break;
      end
      if (o_valid) begin
        if (held_pending) check("feed_held_stable", obs, held);
        if (mode == 2 && !injected && o_q == 4'd2 && o_i == 2'd1) begin
          mm_res_valid = 1'b1;
          mm_h_ready   = 1'b1;
          injected     = 1;
          chk_err      = 1;
          held_pending = 1;
          held         = obs;
        end else begin
          rdy = (mode == 1) ? pat[cyc % 4] : 1'b1;
          mm_h_ready = rdy;
          if (rdy) begin
            check("feed_beats_left", fq.size() > 0, 1);
            exp_d = (fq.size() > 0) ? fq.pop_front() : '0;
            check("feed_data", obs, exp_d);
            held_pending = 0;
          end else begin
            held_pending = 1;
            held         = obs;
          end
        end
      end else if (o_busy && !o_hready) begin
        mm_res_valid = 1'b1;
        check("results_left", iq.size() > 0, 1);
        exp_i = (iq.size() > 0) ? iq.pop_front() : '0;
        check("result_index", {o_q, o_i, o_j}, exp_i);
        res_cnt++;
      end
      if (mode == 1) begin
        start      = 1'($urandom_range(0, 1));
        h_in_valid = 1'b1;
        h_in_r     = N'($urandom);
        h_in_i     = N'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0; h_in_valid = 1'b0; mm_res_valid = 1'b0; mm_h_ready = 1'b0;
    if (aborted) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_valid_low", o_valid, 0);
      check("abort_busy_low", o_busy, 0);
      check("abort_no_done", o_done, 0);
      check("abort_q_cleared", o_q, 0);
      fq.delete();
      iq.delete();
    end else begin
      check("job_done_seen", seen_done, 1);
      check("results_per_job", res_cnt, nq * 8);
      check("feed_beats_all_used", fq.size(), 0);
      check("busy_low_in_done", o_busy, 0);
      check("err_at_done", o_err, mode == 2);
      if (mode == 0) check("min_job_cycles", cyc, nq * 40);
      @(negedge clk);
      check("done_one_cycle", o_done, 0);
      check("idle_after_done", o_busy, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_hready", o_hready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_mm_start", o_start, 0);
    check("rst_indices", {o_q, o_i, o_j}, 0);
    check("rst_data", {o_h_r, o_h_i}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_start", o_busy, 0);

    // reset dominates a simultaneous start
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_beats_start_busy", o_busy, 0);
    check("rst_beats_start_ready", o_hready, 0);

    load_h(16, 1'b0, 1'b0);
    run_job(16, 0);

    load_h(16, 1'b0, 1'b1);
    run_job(16, 1);

    load_h(16, 1'b0, 1'b1);
    run_job(16, 2);

    load_h(16, 1'b0, 1'b0);
    run_job(16, 3);

    load_h(16, 1'b0, 1'b1);
    run_job(16, 0);

    sel = 1'b1;
    @(negedge clk);
    check("small_idle", o_busy, 0);
    load_h(2, 1'b1, 1'b1);
    run_job(2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
